// File: rtl/instr_exec_unit_if.sv
// Bus bundle for instr_exec_unit: run control, instruction-register read port,
// result handshake and status. The slave side is the execution unit.
interface instr_exec_unit_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned OPND_W = 32,
    parameter int unsigned RES_W  = 64
);
    logic                    start;
    logic [ADDR_W-1:0]       first_addr;
    logic [ADDR_W:0]         count;
    logic [ADDR_W-1:0]       read_pointer;
    logic [4+2*OPND_W-1:0]   instruction_word;
    logic                    res_valid;
    logic                    res_ready;
    logic [RES_W-1:0]        result;
    logic [3:0]              res_opcode;
    logic [ADDR_W-1:0]       res_addr;
    logic                    div_zero;
    logic                    illegal_op;
    logic                    busy;
    logic                    done;

    modport master (
        output start, first_addr, count, instruction_word, res_ready,
        input  read_pointer, res_valid, result, res_opcode, res_addr,
               div_zero, illegal_op, busy, done
    );

    modport slave (
        input  start, first_addr, count, instruction_word, res_ready,
        output read_pointer, res_valid, result, res_opcode, res_addr,
               div_zero, illegal_op, busy, done
    );
endinterface

// File: rtl/instr_exec_unit.sv
// Walks a window of the instruction register, executes each opcode on signed
// operands and presents one 64-bit result at a time on a valid/ready handshake.
module instr_exec_unit #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned OPND_W = 32,
    parameter int unsigned RES_W  = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    instr_exec_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HOLD} state_t;
    typedef enum logic [3:0] {
        OP_ZERO  = 4'd0, OP_PASSA = 4'd1, OP_PASSB = 4'd2, OP_ADD = 4'd3,
        OP_SUB   = 4'd4, OP_MULT  = 4'd5, OP_DIV   = 4'd6, OP_MOD = 4'd7
    } op_t;

    state_t                    r_state, w_next;
    logic [ADDR_W-1:0]         r_read_pointer, r_op_addr, r_res_addr;
    logic [ADDR_W:0]           r_remaining;
    logic [3:0]                r_op, r_res_opcode;
    logic [OPND_W-1:0]         r_a, r_b;
    logic signed [RES_W-1:0]   r_result, w_result, w_a, w_b;
    logic                      r_res_valid, r_div_zero, r_illegal, r_done;
    logic                      w_div_zero, w_illegal;
    logic                      w_start_run, w_start_empty, w_accept, w_last;

    assign w_start_run   = (r_state == IDLE) && bus.start && (bus.count != '0);
    assign w_start_empty = (r_state == IDLE) && bus.start && (bus.count == '0);
    assign w_accept      = (r_state == HOLD) && r_res_valid && bus.res_ready;
    assign w_last        = (r_remaining == {{ADDR_W{1'b0}}, 1'b1});

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start_run) w_next = FETCH;
            FETCH:   w_next = EXEC;
            EXEC:    w_next = HOLD;
            HOLD:    if (w_accept) w_next = w_last ? IDLE : FETCH;
            default: w_next = IDLE;
        endcase
    end

    // Operands are sign-extended to the result width so MULT keeps the full product.
    always_comb begin
        w_a        = {{(RES_W-OPND_W){r_a[OPND_W-1]}}, r_a};
        w_b        = {{(RES_W-OPND_W){r_b[OPND_W-1]}}, r_b};
        w_result   = '0;
        w_div_zero = 1'b0;
        w_illegal  = 1'b0;
        case (r_op)
            OP_ZERO:  w_result = '0;
            OP_PASSA: w_result = w_a;
            OP_PASSB: w_result = w_b;
            OP_ADD:   w_result = w_a + w_b;
            OP_SUB:   w_result = w_a - w_b;
            OP_MULT:  w_result = w_a * w_b;
            OP_DIV:   if (w_b == '0) w_div_zero = 1'b1;
                      else           w_result   = w_a / w_b;
            OP_MOD:   if (w_b == '0) w_div_zero = 1'b1;
                      else           w_result   = w_a % w_b;
            default:  w_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_read_pointer <= '0;
            r_remaining    <= '0;
            r_op           <= '0;
            r_a            <= '0;
            r_b            <= '0;
            r_op_addr      <= '0;
            r_res_valid    <= 1'b0;
            r_result       <= '0;
            r_res_opcode   <= '0;
            r_res_addr     <= '0;
            r_div_zero     <= 1'b0;
            r_illegal      <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start_run) begin
                        r_read_pointer <= bus.first_addr;
                        r_remaining    <= bus.count;
                    end else if (w_start_empty) begin
                        r_done <= 1'b1;
                    end
                end
                FETCH: begin
                    r_op      <= bus.instruction_word[2*OPND_W+3 -: 4];
                    r_a       <= bus.instruction_word[2*OPND_W-1 -: OPND_W];
                    r_b       <= bus.instruction_word[OPND_W-1:0];
                    r_op_addr <= r_read_pointer;
                end
                EXEC: begin
                    r_result     <= w_result;
                    r_res_opcode <= r_op;
                    r_res_addr   <= r_op_addr;
                    r_div_zero   <= w_div_zero;
                    r_illegal    <= w_illegal;
                    r_res_valid  <= 1'b1;
                end
                HOLD: begin
                    if (w_accept) begin
                        r_res_valid <= 1'b0;
                        r_remaining <= r_remaining - 1'b1;
                        if (w_last) r_done         <= 1'b1;
                        else        r_read_pointer <= r_read_pointer + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.read_pointer = r_read_pointer;
    assign bus.res_valid    = r_res_valid;
    assign bus.result       = r_result;
    assign bus.res_opcode   = r_res_opcode;
    assign bus.res_addr     = r_res_addr;
    assign bus.div_zero     = r_div_zero;
    assign bus.illegal_op   = r_illegal;
    assign bus.busy         = (r_state != IDLE);
    assign bus.done         = r_done;
endmodule

// File: tb/tb_instr_exec_unit.sv
// Directed bench for instr_exec_unit: instruction register modelled as a
// 32-entry array, expected values hand-computed.
module tb_instr_exec_unit;
    logic clk;
    logic reset_n;
    logic [67:0] mem [32];
    int unsigned checks = 0;
    int unsigned errors = 0;

    instr_exec_unit_if #(.ADDR_W(5), .OPND_W(32), .RES_W(64)) bus ();

    instr_exec_unit #(.ADDR_W(5), .OPND_W(32), .RES_W(64)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    assign bus.instruction_word = mem[bus.read_pointer];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    function automatic logic [67:0] mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        return {op, a, b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        int unsigned n = 0;
        while (bus.res_valid !== 1'b1 && n < 12) begin
            tick();
            n++;
        end
        chk({tag, ".valid_timeout"}, {63'd0, bus.res_valid}, 64'd1);
    endtask

    task automatic expect_res(input string tag, input logic [63:0] r, input logic [3:0] op,
                              input logic [4:0] addr, input logic dz, input logic il);
        wait_valid(tag);
        chk({tag, ".result"}, bus.result, r);
        chk({tag, ".opcode"}, {60'd0, bus.res_opcode}, {60'd0, op});
        chk({tag, ".addr"}, {59'd0, bus.res_addr}, {59'd0, addr});
        chk({tag, ".div_zero"}, {63'd0, bus.div_zero}, {63'd0, dz});
        chk({tag, ".illegal"}, {63'd0, bus.illegal_op}, {63'd0, il});
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
        mem[4]  = mk(4'd3, 32'd5, -32'sd7);
        mem[10] = mk(4'd5, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        mem[11] = mk(4'd6, 32'd9, 32'd0);
        mem[12] = mk(4'd7, -32'sd7, 32'd2);
        mem[13] = mk(4'd9, 32'd1, 32'd1);
        mem[20] = mk(4'd4, 32'd100, 32'd30);
        mem[21] = mk(4'd1, -32'sd5, 32'd1);
        mem[30] = mk(4'd2, 32'd0, 32'd11);
        mem[31] = mk(4'd0, 32'd123, 32'd4);
        mem[0]  = mk(4'd3, -32'sd1, -32'sd1);
        mem[1]  = mk(4'd6, -32'sd7, 32'd2);
        mem[2]  = mk(4'd1, 32'd1, 32'd0);
        mem[3]  = mk(4'd1, 32'd2, 32'd0);

        // reset held with start asserted
        reset_n        = 1'b0;
        bus.start      = 1'b1;
        bus.first_addr = 5'd3;
        bus.count      = 6'd2;
        bus.res_ready  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset.busy", {63'd0, bus.busy}, 64'd0);
        end
        chk("reset.res_valid", {63'd0, bus.res_valid}, 64'd0);
        chk("reset.result", bus.result, 64'd0);
        chk("reset.res_opcode", {60'd0, bus.res_opcode}, 64'd0);
        chk("reset.res_addr", {59'd0, bus.res_addr}, 64'd0);
        chk("reset.read_pointer", {59'd0, bus.read_pointer}, 64'd0);
        chk("reset.div_zero", {63'd0, bus.div_zero}, 64'd0);
        chk("reset.illegal", {63'd0, bus.illegal_op}, 64'd0);
        chk("reset.done", {63'd0, bus.done}, 64'd0);
        reset_n   = 1'b1;
        bus.start = 1'b0;
        tick();

        // single ADD with exact latency
        bus.start = 1'b1; bus.first_addr = 5'd4; bus.count = 6'd1; bus.res_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("add.read_pointer", {59'd0, bus.read_pointer}, 64'd4);
        chk("add.busy", {63'd0, bus.busy}, 64'd1);
        chk("add.valid_e0", {63'd0, bus.res_valid}, 64'd0);
        tick();
        chk("add.valid_e1", {63'd0, bus.res_valid}, 64'd0);
        tick();
        chk("add.valid_e2", {63'd0, bus.res_valid}, 64'd1);
        chk("add.result", bus.result, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("add.opcode", {60'd0, bus.res_opcode}, 64'd3);
        chk("add.addr", {59'd0, bus.res_addr}, 64'd4);
        chk("add.done_early", {63'd0, bus.done}, 64'd0);
        tick();
        chk("add.done", {63'd0, bus.done}, 64'd1);
        chk("add.valid_cleared", {63'd0, bus.res_valid}, 64'd0);
        chk("add.busy_end", {63'd0, bus.busy}, 64'd0);
        tick();
        chk("add.done_once", {63'd0, bus.done}, 64'd0);

        // MULT, DIV by zero, MOD, illegal opcode
        bus.start = 1'b1; bus.first_addr = 5'd10; bus.count = 6'd4;
        tick();
        bus.start = 1'b0;
        expect_res("mult", 64'h3FFF_FFFF_0000_0001, 4'd5, 5'd10, 1'b0, 1'b0);
        tick();
        expect_res("div0", 64'd0, 4'd6, 5'd11, 1'b1, 1'b0);
        tick();
        expect_res("mod", 64'hFFFF_FFFF_FFFF_FFFF, 4'd7, 5'd12, 1'b0, 1'b0);
        tick();
        expect_res("illegal", 64'd0, 4'd9, 5'd13, 1'b0, 1'b1);
        tick();
        chk("arith.done", {63'd0, bus.done}, 64'd1);
        tick();

        // backpressure
        bus.res_ready = 1'b0;
        bus.start = 1'b1; bus.first_addr = 5'd20; bus.count = 6'd2;
        tick();
        bus.start = 1'b0;
        expect_res("bp.sub", 64'd70, 4'd4, 5'd20, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp.hold_valid", {63'd0, bus.res_valid}, 64'd1);
            chk("bp.hold_result", bus.result, 64'd70);
            chk("bp.hold_addr", {59'd0, bus.res_addr}, 64'd20);
            chk("bp.hold_ptr", {59'd0, bus.read_pointer}, 64'd20);
        end
        bus.res_ready = 1'b1;
        tick();
        chk("bp.accept_valid", {63'd0, bus.res_valid}, 64'd0);
        chk("bp.next_ptr", {59'd0, bus.read_pointer}, 64'd21);
        tick();
        chk("bp.fetch_valid", {63'd0, bus.res_valid}, 64'd0);
        tick();
        expect_res("bp.passa", 64'hFFFF_FFFF_FFFF_FFFB, 4'd1, 5'd21, 1'b0, 1'b0);
        tick();
        chk("bp.done", {63'd0, bus.done}, 64'd1);
        tick();

        // wrap-around window with a start issued while busy
        bus.start = 1'b1; bus.first_addr = 5'd30; bus.count = 6'd4;
        tick();
        bus.first_addr = 5'd5; bus.count = 6'd1;
        tick();
        tick();
        bus.start = 1'b0;
        chk("wrap.busy_start_ignored", {59'd0, bus.read_pointer}, 64'd30);
        expect_res("wrap.30", 64'd11, 4'd2, 5'd30, 1'b0, 1'b0);
        tick();
        expect_res("wrap.31", 64'd0, 4'd0, 5'd31, 1'b0, 1'b0);
        tick();
        expect_res("wrap.0", 64'hFFFF_FFFF_FFFF_FFFE, 4'd3, 5'd0, 1'b0, 1'b0);
        tick();
        expect_res("wrap.1", 64'hFFFF_FFFF_FFFF_FFFD, 4'd6, 5'd1, 1'b0, 1'b0);
        tick();
        chk("wrap.done", {63'd0, bus.done}, 64'd1);
        tick();
        chk("wrap.idle_busy", {63'd0, bus.busy}, 64'd0);
        chk("wrap.idle_valid", {63'd0, bus.res_valid}, 64'd0);

        // count = 0
        bus.start = 1'b1; bus.first_addr = 5'd7; bus.count = 6'd0;
        tick();
        bus.start = 1'b0;
        chk("cnt0.done", {63'd0, bus.done}, 64'd1);
        chk("cnt0.busy", {63'd0, bus.busy}, 64'd0);
        chk("cnt0.valid", {63'd0, bus.res_valid}, 64'd0);
        tick();
        chk("cnt0.done_once", {63'd0, bus.done}, 64'd0);
        chk("cnt0.valid_after", {63'd0, bus.res_valid}, 64'd0);

        // reset during HOLD of the second instruction
        bus.start = 1'b1; bus.first_addr = 5'd2; bus.count = 6'd5;
        tick();
        bus.start = 1'b0;
        expect_res("rst.first", 64'd1, 4'd1, 5'd2, 1'b0, 1'b0);
        tick();
        bus.res_ready = 1'b0;
        expect_res("rst.second", 64'd2, 4'd1, 5'd3, 1'b0, 1'b0);
        reset_n = 1'b0;
        tick();
        chk("rst.valid", {63'd0, bus.res_valid}, 64'd0);
        chk("rst.done", {63'd0, bus.done}, 64'd0);
        chk("rst.busy", {63'd0, bus.busy}, 64'd0);
        chk("rst.result", bus.result, 64'd0);
        chk("rst.read_pointer", {59'd0, bus.read_pointer}, 64'd0);
        reset_n = 1'b1;
        bus.res_ready = 1'b1;
        tick();
        chk("rst.after_done", {63'd0, bus.done}, 64'd0);
        chk("rst.after_busy", {63'd0, bus.busy}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_exec_unit.md
Name: instr_exec_unit

Overview:
- Downstream consumer of the instruction register.
- On a start command it walks read_pointer through a contiguous window of stored instructions. It captures each instruction_word, executes the opcode on the signed operands, and presents a 64-bit result on a valid/ready output handshake.
- It provides the read side of the instruction register plus the arithmetic stage that the testbench checks against its scoreboard.

Parameters:
- ADDR_W, 5, read_pointer width; register depth = 2**ADDR_W (32)
- OPND_W, 32, signed operand width
- RES_W, 64, result width (holds the full signed product)

Ports:
- clk  input  1  single clock, rising edge
- reset_n  input  1  synchronous, active-low reset
- start  input  1  one-cycle request to begin a run; sampled only in IDLE
- first_addr  input  ADDR_W  address of the first instruction in the run
- count  input  ADDR_W+1  number of instructions in the run (0..32)
- read_pointer  output  ADDR_W  address driven to the instruction register
- instruction_word  input  4+2*OPND_W  {opcode[3:0], operand_a, operand_b}; combinational read of read_pointer
- res_valid  output  1  result is available
- res_ready  input  1  consumer accepts the result
- result  output  RES_W  signed result
- res_opcode  output  4  opcode that produced the result
- res_addr  output  ADDR_W  address the instruction came from
- div_zero  output  1  DIV/MOD with operand_b == 0; qualified by res_valid
- illegal_op  output  1  opcode 8..15; qualified by res_valid
- busy  output  1  high in any state except IDLE
- done  output  1  one-cycle pulse when a run completes

Behaviour:
- Reset: synchronous, active-low. Sampled only at the clk edge and takes priority over everything else.
- Reset values: state=IDLE, read_pointer=0, res_valid=0, result=0, res_opcode=0, res_addr=0, div_zero=0, illegal_op=0, busy=0, done=0.
- Reset mid-run aborts the run. Any pending result is dropped and no done pulse is issued.
- Opcode encoding: ZERO=0, PASSA=1, PASSB=2, ADD=3, SUB=4, MULT=5, DIV=6, MOD=7.
- FSM states: IDLE, FETCH, EXEC, HOLD.
- IDLE:
  - start=1 and count>0: latch first_addr into read_pointer, latch count into the remaining counter, go to FETCH.
  - start=1 and count=0: stay in IDLE and pulse done on the next cycle.
- FETCH: at the edge, capture instruction_word and res_addr=read_pointer into the operand register, then go to EXEC.
- EXEC: at the edge, register result, res_opcode and flags; set res_valid=1; go to HOLD.
- HOLD:
  - result, res_opcode, res_addr and the flags stay stable while res_valid=1 and res_ready=0.
  - On res_valid & res_ready at an edge: clear res_valid and decrement remaining.
  - If remaining becomes 0: go to IDLE and pulse done=1 for the next cycle.
  - Otherwise: read_pointer = read_pointer+1, go to FETCH.
- read_pointer wraps modulo 32: 31+1 = 0. A run with count=32 visits every entry exactly once.
- Latency: start edge E0, capture at E1, res_valid high after E2. With res_ready held at 1, throughput is one result per 3 cycles.
- start while busy=1 is ignored. first_addr and count are sampled only on an accepted start.
- Arithmetic: operands are sign-extended to RES_W before each operation.
  - ZERO: 0
  - PASSA: a
  - PASSB: b
  - ADD: a+b
  - SUB: a-b
  - MULT: full signed a*b
  - DIV: truncates toward zero
  - MOD: remainder takes the sign of the dividend
- DIV or MOD with b=0: result=0, div_zero=1.
- Opcode 8..15: result=0, illegal_op=1.
- Flags are cleared on the next EXEC and on reset.
- res_ready has no effect unless res_valid=1.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with start=1 -> all outputs at reset values, busy stays 0.
- Single ADD: entry 4 = {ADD, 5, -7}; start, first_addr=4, count=1, res_ready=1 -> read_pointer=4; res_valid after 2 edges with result=-2, res_opcode=3, res_addr=4; done pulses once.
- Multiply and divide by zero:
  - {MULT, 32'h7FFFFFFF, 32'h7FFFFFFF} -> result=64'h3FFFFFFF00000001.
  - {DIV, 9, 0} -> result=0, div_zero=1.
  - {MOD, -7, 2} -> result=-1.
- Backpressure: res_ready=0 for 5 cycles -> result and res_addr stable with res_valid=1; the next fetch starts only after the accepting edge.
- Wrap and edge counts: first_addr=30, count=4 -> res_addr sequence 30, 31, 0, 1, then done. count=0 -> done with no res_valid. start while busy -> ignored.
- Reset mid-run: reset_n=0 during HOLD of the 2nd of 5 instructions -> res_valid=0 and done=0 next cycle; state IDLE.
